obstacle_scheduler: RTL and testbench

//  Game-level sequencer for the obstacle modules (lasers etc.). Picks the next obstacle pseudo-randomly
//  and drives the shared selected/play_selected/done_control bus. Waits for that obstacle's done,

---
 rtl/obstacle_pkg.sv | 35 +++
 rtl/obstacle_scheduler_lfsr16.sv | 17 +
 rtl/obstacle_scheduler.sv | 177 +++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types, constants and helpers for the obstacle scheduler.
// IDLE wait enable | GAP inter-obstacle gap | PICK choose slot | START strobe | RUN wait done/timeout
package obstacle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_PICK  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  localparam logic [3:0] OBST_LASERS = 4'b0001;
  localparam logic [3:0] OBST_BEAMS  = 4'b0010;
  localparam logic [3:0] OBST_WALLS  = 4'b0100;
  localparam logic [3:0] OBST_DRONES = 4'b1000;

  localparam int unsigned ROUND_W = 8;
  localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

  function automatic logic [3:0] slot_mask(int unsigned n);
    logic [3:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) m[i] = (i < n);
    return m;
  endfunction

  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(logic [15:0] q);
    logic fb;
    fb = q[0] ^ q[2] ^ q[3] ^ q[5];
    return {fb, q[15:1]};
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// Free-running 16-bit LFSR used as the obstacle pick source.
module lfsr16
  import obstacle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-level obstacle sequencer: gap, pseudo-random pick, start strobe, wait for done or watchdog.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int unsigned N_OBST         = 4,
  parameter int unsigned GAP_CYCLES     = 32_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned NO_REPEAT      = 1
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               game_on,
  input  logic               menu_on,
  input  logic [3:0]         obstacle_done,
  input  logic [3:0]         obstacle_work,
  output logic [3:0]         selected,
  output logic               play_selected,
  output logic               done_control,
  output logic               obstacle_active,
  output logic [ROUND_W-1:0] round_count,
  output logic               timeout_err
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] SLOT_MASK = slot_mask(N_OBST);

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [1:0]         last_idx_q, last_idx_d;
  logic               last_valid_q, last_valid_d;
  logic [3:0]         selected_q, selected_d;
  logic               play_q, play_d;
  logic               done_ctl_q, done_ctl_d;
  logic               active_q;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               tout_q, tout_d;
  logic [15:0]        lfsr_q;
  logic [1:0]         pick_idx;
  logic               enable;
  logic               done_sel;
  logic               unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk  (pclk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:2];
  assign enable      = game_on && !menu_on;
  assign done_sel    = |(obstacle_done & selected_q);

  always_comb begin
    pick_idx = 2'({30'd0, lfsr_q[1:0]} % N_OBST);
    if ((NO_REPEAT != 0) && (N_OBST > 1) && last_valid_q && (pick_idx == last_idx_q))
      pick_idx = 2'(({30'd0, pick_idx} + 32'd1) % N_OBST);
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    run_cnt_d    = run_cnt_q;
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    selected_d   = selected_q;
    play_d       = 1'b0;
    done_ctl_d   = 1'b0;
    round_d      = round_q;
    tout_d       = tout_q;
    case (state_q)
      ST_IDLE: begin
        selected_d = '0;
        if (enable) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          round_d   = '0;
          tout_d    = 1'b0;
        end
      end
      ST_GAP: begin
        selected_d = '0;
        if (gap_cnt_q == GAP_LAST) state_d = ST_PICK;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      ST_PICK: begin
        case (pick_idx)
          2'd0:    selected_d = OBST_LASERS;
          2'd1:    selected_d = OBST_BEAMS;
          2'd2:    selected_d = OBST_WALLS;
          default: selected_d = OBST_DRONES;
        endcase
        last_idx_d   = pick_idx;
        last_valid_d = 1'b1;
        state_d      = ST_START;
        play_d       = 1'b1;
        done_ctl_d   = 1'b1;
      end
      ST_START: begin
        state_d   = ST_RUN;
        run_cnt_d = '0;
        play_d    = 1'b1;
      end
      ST_RUN: begin
        if (done_sel) begin
          state_d    = ST_GAP;
          gap_cnt_d  = '0;
          selected_d = '0;
          round_d    = (round_q == ROUND_MAX) ? round_q : round_q + ROUND_W'(1);
        end else if (run_cnt_q == RUN_LAST) begin
          state_d    = ST_GAP;
          gap_cnt_d  = '0;
          selected_d = '0;
          tout_d     = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
          play_d    = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        selected_d = '0;
      end
    endcase
    if ((state_q != ST_IDLE) && !enable) begin
      state_d      = ST_IDLE;
      selected_d   = '0;
      play_d       = 1'b0;
      done_ctl_d   = 1'b0;
      round_d      = round_q;
      tout_d       = tout_q;
      last_idx_d   = last_idx_q;
      last_valid_d = last_valid_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      run_cnt_q    <= '0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      selected_q   <= '0;
      play_q       <= 1'b0;
      done_ctl_q   <= 1'b0;
      active_q     <= 1'b0;
      round_q      <= '0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      run_cnt_q    <= run_cnt_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      selected_q   <= selected_d;
      play_q       <= play_d;
      done_ctl_q   <= done_ctl_d;
      active_q     <= |(obstacle_work & SLOT_MASK);
      round_q      <= round_d;
      tout_q       <= tout_d;
    end
  end

  assign selected        = selected_q;
  assign play_selected   = play_q;
  assign done_control    = done_ctl_q;
  assign obstacle_active = active_q;
  assign round_count     = round_q;
  assign timeout_err     = tout_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: expected start strobes are queued, a monitor checks them.
module tb_obstacle_scheduler;

  localparam int G = 10;
  localparam int T = 100;
  localparam int N = 4;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       game_on = 1'b0;
  logic       menu_on = 1'b0;
  logic [3:0] obstacle_done = 4'd0;
  logic [3:0] obstacle_work = 4'd0;
  logic [3:0] selected;
  logic       play_selected;
  logic       done_control;
  logic       obstacle_active;
  logic [7:0] round_count;
  logic       timeout_err;

  obstacle_scheduler #(
    .N_OBST         (N),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T),
    .LFSR_SEED      (16'hACE1),
    .NO_REPEAT      (1)
  ) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .game_on         (game_on),
    .menu_on         (menu_on),
    .obstacle_done   (obstacle_done),
    .obstacle_work   (obstacle_work),
    .selected        (selected),
    .play_selected   (play_selected),
    .done_control    (done_control),
    .obstacle_active (obstacle_active),
    .round_count     (round_count),
    .timeout_err     (timeout_err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0] sel;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;
  logic [1:0]  last_idx = 2'd0;
  logic        last_valid = 1'b0;
  logic [3:0]  cur_sel = 4'd0;
  logic [3:0]  seen_mask = 4'd0;
  logic [3:0]  prev_sel = 4'd0;
  logic        have_prev = 1'b0;
  logic        prev_dc = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(logic [15:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  endfunction

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Call at the negedge whose following posedge samples the event that re-enters GAP.
  task automatic expect_start();
    logic [15:0] l;
    logic [1:0]  idx;
    exp_t        e;
    l = m_lfsr;
    for (int k = 0; k < G + 1; k++) l = lfsr_step(l);
    idx = l[1:0];
    if (last_valid && idx == last_idx) idx = idx + 2'd1;
    e.sel = 4'b0001 << idx;
    e.cyc = cyc + G + 2;
    exp_q.push_back(e);
    last_idx   = idx;
    last_valid = 1'b1;
    cur_sel    = e.sel;
  endtask

  task automatic wait_start(int budget);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!done_control && n < budget);
    chk("start_wait", 32'(done_control), 1);
  endtask

  task automatic finish_run(int idx_note);
    @(negedge pclk);
    obstacle_done = cur_sel;
    expect_start();
    @(negedge pclk);
    obstacle_done = 4'd0;
    if (idx_note < 0) chk("round_after_done", 32'(round_count), 1);
  endtask

  initial begin
    int s;
    fork
      forever begin
        @(negedge pclk);
        if (done_control) begin
          exp_t e;
          chk("strobe_single", 32'(prev_dc), 0);
          chk("start_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("start_selected", 32'(selected), 32'(e.sel));
            chk("start_cycle", 32'(cyc), 32'(e.cyc));
          end
          chk("start_play", 32'(play_selected), 1);
          if (have_prev) chk("no_repeat", 32'(selected != prev_sel), 1);
          prev_sel  = selected;
          have_prev = 1'b1;
          seen_mask = seen_mask | selected;
        end
        prev_dc = done_control;
      end
    join_none

    // Reset with no clock edge needed
    #1 rst_n = 1'b0;
    #1;
    chk("rst_selected", 32'(selected), 0);
    chk("rst_play", 32'(play_selected), 0);
    chk("rst_done_ctl", 32'(done_control), 0);
    chk("rst_active", 32'(obstacle_active), 0);
    chk("rst_round", 32'(round_count), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;

    // obstacle_active is a registered OR of work flags
    @(negedge pclk);
    obstacle_work = 4'b0100;
    @(negedge pclk);
    chk("active_set", 32'(obstacle_active), 1);
    obstacle_work = 4'b0000;
    @(negedge pclk);
    chk("active_clr", 32'(obstacle_active), 0);

    // 1: enable -> first strobe 12 cycles later
    game_on = 1'b1;
    expect_start();
    wait_start(40);

    // 2: done on the selected slot
    finish_run(-1);
    chk("play_after_done", 32'(play_selected), 0);
    wait_start(40);

    // 3: done on a non-selected slot is ignored, then 4: watchdog
    s = cyc;
    @(negedge pclk);
    obstacle_done = {cur_sel[2:0], cur_sel[3]};
    @(negedge pclk);
    obstacle_done = 4'd0;
    chk("foreign_done_round", 32'(round_count), 1);
    chk("foreign_done_play", 32'(play_selected), 1);
    while (cyc < s + T) @(negedge pclk);
    chk("pre_timeout_err", 32'(timeout_err), 0);
    chk("pre_timeout_play", 32'(play_selected), 1);
    expect_start();
    @(negedge pclk);
    chk("timeout_err_set", 32'(timeout_err), 1);
    chk("timeout_play", 32'(play_selected), 0);
    chk("timeout_round", 32'(round_count), 1);
    wait_start(40);
    chk("timeout_sticky", 32'(timeout_err), 1);

    // Restart through a menu pulse clears the watchdog flag
    @(negedge pclk);
    menu_on = 1'b1;
    @(negedge pclk);
    chk("menu_play", 32'(play_selected), 0);
    chk("menu_selected", 32'(selected), 0);
    chk("menu_err_held", 32'(timeout_err), 1);
    menu_on = 1'b0;
    expect_start();
    @(negedge pclk);
    chk("restart_err_clr", 32'(timeout_err), 0);
    chk("restart_round", 32'(round_count), 0);

    // 5: 50 obstacles, all slots, no repeats
    seen_mask = 4'd0;
    for (int i = 0; i < 50; i++) begin
      wait_start(40);
      finish_run(i);
    end
    chk("round_50", 32'(round_count), 50);
    chk("all_slots_seen", 32'(seen_mask), 32'hF);

    // 6: menu in the same cycle as done -> IDLE, count untouched
    wait_start(40);
    @(negedge pclk);
    menu_on = 1'b1;
    obstacle_done = cur_sel;
    @(negedge pclk);
    chk("abort_round", 32'(round_count), 50);
    chk("abort_play", 32'(play_selected), 0);
    chk("abort_selected", 32'(selected), 0);
    chk("abort_done_ctl", 32'(done_control), 0);
    menu_on = 1'b0;
    obstacle_done = 4'd0;
    expect_start();
    @(negedge pclk);
    chk("restart2_round", 32'(round_count), 0);

    // Saturation of the completion counter
    for (int i = 0; i < 256; i++) begin
      wait_start(40);
      finish_run(i);
      if (i == 254) chk("round_255", 32'(round_count), 255);
    end
    chk("round_saturated", 32'(round_count), 255);

    // Async reset mid-RUN clears outputs before the next edge
    wait_start(40);
    obstacle_work = 4'b0001;
    @(negedge pclk);
    chk("midrun_play", 32'(play_selected), 1);
    chk("midrun_active", 32'(obstacle_active), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_selected", 32'(selected), 0);
    chk("arst_play", 32'(play_selected), 0);
    chk("arst_done_ctl", 32'(done_control), 0);
    chk("arst_active", 32'(obstacle_active), 0);
    chk("arst_round", 32'(round_count), 0);
    chk("arst_timeout", 32'(timeout_err), 0);
    chk("no_pending_starts", 32'(exp_q.size()), 0);
    repeat (2) @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
